// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed N-digit 7-segment scanner.
// Each digit slot lasts PRESCALE cycles. The first BLANK_CYCLES of a slot
// keep all anodes off to suppress ghosting; the rest of the slot lights the
// selected digit. Disabled digits are skipped. A frame tick marks each wrap.
module display_scan_ctrl #(
    parameter int N_DIGITS         = 4,
    parameter int SEL_W            = 2,
    parameter int PRESCALE         = 100000,
    parameter int BLANK_CYCLES     = 16,
    parameter int ANODE_ACTIVE_LOW = 1
) (
    input  logic                i_Clk,
    input  logic                i_Reset,
    input  logic                i_Enable,
    input  logic [N_DIGITS-1:0] i_DigitMask,
    output logic [SEL_W-1:0]    o_Sel,
    output logic [N_DIGITS-1:0] o_Anodos,
    output logic                o_Blank,
    output logic                o_FrameTick
);

    localparam int                 CNT_W      = $clog2(PRESCALE);
    localparam logic [CNT_W-1:0]   SLOT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0]   BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic               ACT_LVL    = (ANODE_ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [N_DIGITS-1:0] ALL_OFF   = {N_DIGITS{~ACT_LVL}};

    typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt, cnt_next;
    logic [SEL_W-1:0]      sel, sel_next;
    logic [N_DIGITS-1:0]   anodes, anodes_next;
    logic                  blank, blank_next;
    logic                  frame_tick, frame_tick_next;

    // Lowest enabled digit index; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_idx(input logic [N_DIGITS-1:0] m);
        logic [SEL_W-1:0] r;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (!found && m[k]) begin
                r     = SEL_W'(k);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // First enabled index scanning upward from cur+1 (mod N_DIGITS).
    // The doubled mask lets a plain shift handle the wrap-around; if only
    // cur is enabled the search comes back round to cur itself.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0]    cur,
                                                  input logic [N_DIGITS-1:0] m);
        logic [2*N_DIGITS-1:0] rot;
        logic [SEL_W-1:0]      r;
        logic                  found;
        rot   = {m, m} >> (int'(cur) + 1);
        r     = cur;
        found = 1'b0;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (!found && rot[k]) begin
                r     = SEL_W'((int'(cur) + 1 + k) % N_DIGITS);
                found = 1'b1;
            end
        end
        return r;
    endfunction

    // State and output registers; reset forces the idle, dark display.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sel        <= '0;
            anodes     <= ALL_OFF;
            blank      <= 1'b1;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            sel        <= sel_next;
            anodes     <= anodes_next;
            blank      <= blank_next;
            frame_tick <= frame_tick_next;
        end
    end

    // Slot sequencing, digit advance and anode decode from the present state.
    always_comb begin
        state_next      = state;
        cnt_next        = cnt;
        sel_next        = sel;
        frame_tick_next = 1'b0;
        anodes_next     = ALL_OFF;

        // Anodes follow the current state one cycle late; a digit whose mask
        // bit drops goes dark immediately while the slot keeps running.
        for (int k = 0; k < N_DIGITS; k++) begin
            if (state == ON && i_DigitMask[k] && int'(sel) == k) begin
                anodes_next[N_DIGITS-1-k] = ACT_LVL;
            end
        end

        if (!i_Enable || i_DigitMask == '0) begin
            state_next  = IDLE;
            cnt_next    = '0;
            sel_next    = '0;
            anodes_next = ALL_OFF;
        end else begin
            case (state)
                IDLE: begin
                    sel_next   = lowest_idx(i_DigitMask);
                    cnt_next   = '0;
                    state_next = (BLANK_CYCLES == 0) ? ON : BLANK;
                end
                BLANK: begin
                    cnt_next = cnt + 1'b1;
                    if (cnt == BLANK_LAST) begin
                        state_next = ON;
                    end
                end
                ON: begin
                    if (cnt == SLOT_LAST) begin
                        cnt_next        = '0;
                        sel_next        = next_idx(sel, i_DigitMask);
                        frame_tick_next = (sel_next <= sel);
                        state_next      = (BLANK_CYCLES == 0) ? ON : BLANK;
                    end else begin
                        cnt_next = cnt + 1'b1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    sel_next   = '0;
                end
            endcase
        end

        blank_next = (anodes_next == ALL_OFF);
    end

    assign o_Sel       = sel;
    assign o_Anodos    = anodes;
    assign o_Blank     = blank;
    assign o_FrameTick = frame_tick;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two instances (with and without blanking,
// opposite anode polarity) driven by directed slot sequences. Expected
// per-cycle outputs are queued with a cycle tag and checked by a monitor.
module tb_display_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_a, en_a, rst_b, en_b;
    logic [3:0] mask_a, mask_b;
    logic [1:0] sel_a, sel_b;
    logic [3:0] an_a, an_b;
    logic       blank_a, blank_b, tick_a, tick_b;

    int cyc        = 0;
    int checks     = 0;
    int errors     = 0;
    bit stim_done  = 1'b0;

    typedef struct {
        int         cyc;
        bit         dut;
        int         sel;
        logic [3:0] an;
        logic       blank;
        logic       tick;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    display_scan_ctrl #(
        .N_DIGITS(4), .SEL_W(2), .PRESCALE(8), .BLANK_CYCLES(2), .ANODE_ACTIVE_LOW(1)
    ) dut_a (
        .i_Clk(clk), .i_Reset(rst_a), .i_Enable(en_a), .i_DigitMask(mask_a),
        .o_Sel(sel_a), .o_Anodos(an_a), .o_Blank(blank_a), .o_FrameTick(tick_a)
    );

    display_scan_ctrl #(
        .N_DIGITS(4), .SEL_W(2), .PRESCALE(8), .BLANK_CYCLES(0), .ANODE_ACTIVE_LOW(0)
    ) dut_b (
        .i_Clk(clk), .i_Reset(rst_b), .i_Enable(en_b), .i_DigitMask(mask_b),
        .o_Sel(sel_b), .o_Anodos(an_b), .o_Blank(blank_b), .o_FrameTick(tick_b)
    );

    function automatic logic [3:0] off_lvl(input bit dut);
        return dut ? 4'b0000 : 4'b1111;
    endfunction

    // Digit d lights anode bit 3-d.
    function automatic logic [3:0] act(input bit dut, input int d);
        logic [3:0] oh;
        oh = 4'b1000 >> d;
        return dut ? oh : ~oh;
    endfunction

    task automatic push(input bit dut, input int sel, input logic [3:0] an, input bit tick);
        exp_t e;
        e.cyc   = cyc;
        e.dut   = dut;
        e.sel   = sel;
        e.an    = an;
        e.blank = (an == off_lvl(dut));
        e.tick  = tick;
        q.push_back(e);
    endtask

    // One digit slot starting at the next edge: digit d replaces prev
    // (prev<0 means entry from idle). Optionally rewrites the mask after step chg_j.
    task automatic slot(input bit dut, input int d, input int prev, input bit wrap,
                        input int nsteps, input int chg_j, input logic [3:0] chg_mask);
        logic [3:0] m, an;
        int         nblank;
        nblank = dut ? 0 : 2;
        for (int j = 0; j < nsteps; j++) begin
            m = dut ? mask_b : mask_a;
            @(posedge clk);
            #1;
            if (j == 0)
                an = (prev >= 0 && m[prev[1:0]]) ? act(dut, prev) : off_lvl(dut);
            else if (j <= nblank)
                an = off_lvl(dut);
            else
                an = m[d[1:0]] ? act(dut, d) : off_lvl(dut);
            push(dut, d, an, (j == 0) && wrap);
            if (j == chg_j) begin
                if (dut) mask_b = chg_mask;
                else     mask_a = chg_mask;
            end
        end
    endtask

    task automatic edge_idle(input bit dut);
        @(posedge clk);
        #1;
        push(dut, 0, off_lvl(dut), 1'b0);
    endtask

    // Stimulus
    initial begin
        rst_a = 1'b1; en_a = 1'b0; mask_a = 4'b0000;
        rst_b = 1'b1; en_b = 1'b0; mask_b = 4'b0000;
        repeat (2) begin
            @(posedge clk);
            #1;
            push(1'b0, 0, 4'b1111, 1'b0);
            push(1'b1, 0, 4'b0000, 1'b0);
        end

        // All four digits, ring 0..3 then wrap.
        rst_a = 1'b0; en_a = 1'b1; mask_a = 4'b1111;
        slot(0, 0, -1, 0, 8, -1, 4'b0);
        slot(0, 1,  0, 0, 8, -1, 4'b0);
        slot(0, 2,  1, 0, 8, -1, 4'b0);
        slot(0, 3,  2, 0, 8, -1, 4'b0);
        slot(0, 0,  3, 1, 8, -1, 4'b0);

        // Digits 1 and 3 only.
        mask_a = 4'b1010;
        slot(0, 1, 0, 0, 8, -1, 4'b0);
        slot(0, 3, 1, 0, 8, -1, 4'b0);
        slot(0, 1, 3, 1, 8, -1, 4'b0);
        slot(0, 3, 1, 0, 8, -1, 4'b0);

        // Single digit 2 re-selects itself every slot.
        mask_a = 4'b0100;
        slot(0, 2, 3, 1, 8, -1, 4'b0);
        slot(0, 2, 2, 1, 8, -1, 4'b0);
        slot(0, 2, 2, 1, 8, -1, 4'b0);

        // Current digit masked off mid-slot at cnt=4.
        mask_a = 4'b1111;
        slot(0, 3, 2, 0, 8, -1, 4'b0);
        slot(0, 0, 3, 1, 8,  4, 4'b1110);
        slot(0, 1, 0, 0, 8, -1, 4'b0);

        // Enable dropped mid-ON.
        slot(0, 2, 1, 0, 5, -1, 4'b0);
        en_a = 1'b0;
        edge_idle(0);
        edge_idle(0);

        // Re-enable, then reset mid-ON with enable still high.
        en_a = 1'b1;
        slot(0, 1, -1, 0, 5, -1, 4'b0);
        rst_a = 1'b1;
        edge_idle(0);
        rst_a = 1'b0;
        slot(0, 1, -1, 0, 8, -1, 4'b0);
        slot(0, 2,  1, 0, 8, -1, 4'b0);

        // No-blank, active-high instance.
        en_a  = 1'b0;
        rst_b = 1'b0; en_b = 1'b1; mask_b = 4'b1111;
        slot(1, 0, -1, 0, 8, -1, 4'b0);
        slot(1, 1,  0, 0, 8, -1, 4'b0);
        slot(1, 2,  1, 0, 8, -1, 4'b0);
        slot(1, 3,  2, 0, 8, -1, 4'b0);
        slot(1, 0,  3, 1, 8, -1, 4'b0);

        @(negedge clk);
        #1;
        stim_done = 1'b1;
    end

    // Monitor: compares queued expectations against the DUT mid-cycle.
    initial begin
        logic [1:0] g_sel;
        logic [3:0] g_an;
        logic       g_blank, g_tick;
        while (!stim_done) begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= cyc) begin
                mon_e   = q.pop_front();
                g_sel   = mon_e.dut ? sel_b   : sel_a;
                g_an    = mon_e.dut ? an_b    : an_a;
                g_blank = mon_e.dut ? blank_b : blank_a;
                g_tick  = mon_e.dut ? tick_b  : tick_a;
                checks++;
                if (mon_e.cyc != cyc || int'(g_sel) != mon_e.sel || g_an !== mon_e.an ||
                    g_blank !== mon_e.blank || g_tick !== mon_e.tick) begin
                    errors++;
                    $display("FAIL dut%s cyc=%0d (expected at %0d): got sel=%0d an=%b blank=%b tick=%b, want sel=%0d an=%b blank=%b tick=%b",
                             mon_e.dut ? "B" : "A", cyc, mon_e.cyc, g_sel, g_an, g_blank, g_tick,
                             mon_e.sel, mon_e.an, mon_e.blank, mon_e.tick);
                end
            end
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expectations: got %0d unchecked, want 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog timeout");
    end

endmodule
